axil_seq_self_test: RTL and testbench
=====================================

// Module: axil_seq_self_test
// PURPOSE
//  Parametrised AXI4-Lite master that runs a write-then-readback self-test on a slave register bank (e.g. the AES custom IP).
//  Writes NUM_WORDS pattern words at BASE_ADDR+i*ADDR_STRIDE, reads them back, compares each word and reports pass/fail with error count.
//  Sits beside the slave in the block design; driven by a CPU-visible start bit or a bench.
// PARAMETERS
//  ADDR_WIDTH   32     AXI address width
//  DATA_WIDTH   32     AXI data width (32 or 64)
//  NUM_WORDS    4      words per test run, >=1
//  BASE_ADDR    0      first target address
//  ADDR_STRIDE  4      byte increment between words
//  MAX_WAIT     255    per-handshake timeout, cycles (used only with AXIL_SELFTEST_TIMEOUT_EN)
// PORTS
//  ACLK           in   1              clock
//  ARESET         in   1              synchronous, active-high reset
//  start          in   1              begin a run (sampled in IDLE/DONE only)
//  seed           in   DATA_WIDTH     first pattern word, latched on start
//  pat_inv        in   1              0: word i = seed+i; 1: word i = ~(seed+i); latched on start
//  busy           out  1              run in progress
//  done           out  1              run finished; held until next accepted start
//  pass           out  1              valid when done: err_count==0 and no timeout
//  err_count      out  $clog2(2*NUM_WORDS+1)  mismatches + non-OKAY responses, saturating
//  first_err_idx  out  $clog2(NUM_WORDS)      index of first failing word
//  timeout        out  1              handshake timed out (0 without macro)
//  M_AXI_AW*/W*/B*/AR*/R*             standard AXI4-Lite master channels; AWPROT=ARPROT=3'b000, WSTRB all ones
// BEHAVIOUR
//  Reset: all outputs 0, all VALID/READY 0, FSM IDLE, counters 0.
//  FSM: IDLE -> WR_REQ -> WR_RESP -> (next word: WR_REQ | last: RD_REQ) -> RD_RESP -> (next: RD_REQ | last: DONE); DONE -> WR_REQ on start.
//  WR_REQ: AWVALID and WVALID asserted together same cycle; each drops the cycle after its own handshake; both done -> WR_RESP.
//  WR_RESP: BREADY=1; on BVALID, BRESP!=OKAY increments err_count; index advances.
//  RD_REQ: ARVALID until ARREADY. RD_RESP: RREADY=1; on RVALID compare RDATA with expected word i; mismatch or RRESP!=OKAY -> one error (counted once per word).
//  VALID never deasserted before its handshake; address/data stable while VALID high.
//  Address = BASE_ADDR + i*ADDR_STRIDE, computed modulo 2^ADDR_WIDTH (wraps silently).
//  Pattern arithmetic modulo 2^DATA_WIDTH; seed+i wraps.
//  first_err_idx captured on first error only; 0 if none.
//  start while busy: ignored. start in DONE: clears done/pass/err_count/timeout, new run begins next cycle.
//  busy rises the cycle after start; done rises the cycle after last R handshake.
//  NUM_WORDS=1: single write, single read, then DONE.
//  ARESET mid-run: next edge returns to IDLE, VALIDs drop, no completion reported.
//  Minimum run latency with zero-wait slave: 4*NUM_WORDS+1 cycles start->done.
// CONFIGURATION
//  AXIL_SELFTEST_TIMEOUT_EN defined: wait counter resets on every state entry; reaching MAX_WAIT in any WR_*/RD_* state
//   -> drop all VALID/READY, timeout=1, pass=0, go DONE.
//  Undefined: no counter; FSM waits indefinitely; timeout tied 0.
// STRUCTURE
//  Package axil_self_test_pkg: state_t enum, AXI_RESP_OKAY/EXOKAY/SLVERR/DECERR constants.
//  Sub-module axil_st_pattern_gen: combinational expected-word from (seed, pat_inv, index); shared by write and compare paths.
// TESTING
//  Zero-wait RAM slave, NUM_WORDS=4, seed=1, pat_inv=0 -> writes 1,2,3,4 @0x0,0x4,0x8,0xC; done, pass=1, err_count=0.
//  Slave corrupts read of word 2 (returns 0) -> pass=0, err_count=1, first_err_idx=2.
//  Slave AWREADY delayed 3 cycles, WREADY immediate -> WVALID drops first, AWVALID held stable; run passes.
//  seed=32'hFFFF_FFFF, pat_inv=1 -> words ~FFFFFFFF,~0,~1,~2 = 0,FFFFFFFF,FFFFFFFE,FFFFFFFD; pass=1.
//  BRESP=SLVERR on word 0, data correct -> err_count=1, first_err_idx=0, pass=0.
//  With AXIL_SELFTEST_TIMEOUT_EN, MAX_WAIT=16, ARREADY never asserted -> timeout=1, done=1, pass=0, ARVALID low after expiry; ARESET mid-run -> IDLE, busy=0.

Source files
------------

// File: rtl/axil_self_test_pkg.sv
// -----------------------------------------------------------------------------
// axil_self_test_pkg
// Shared types and constants for the AXI4-Lite write/readback self-test master.
//   state_t      : sequencer state encoding
//   AXI_RESP_*   : AXI response codes
//   resp_is_okay : true when a BRESP/RRESP code is OKAY
// -----------------------------------------------------------------------------
package axil_self_test_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_WR_REQ  = 3'd1,
    ST_WR_RESP = 3'd2,
    ST_RD_REQ  = 3'd3,
    ST_RD_RESP = 3'd4,
    ST_DONE    = 3'd5
  } state_t;

  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_EXOKAY = 2'b01;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
  localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

  function automatic logic resp_is_okay(input logic [1:0] resp);
    return (resp == AXI_RESP_OKAY);
  endfunction

endpackage

// File: rtl/axil_st_pattern_gen.sv
// -----------------------------------------------------------------------------
// axil_st_pattern_gen
// Combinational expected-word generator. One instance feeds both the write
// data path and the readback comparator so they can never disagree.
//   seed_i    : latched seed of the current run
//   pat_inv_i : 1 selects the inverted pattern
//   idx_i     : word index within the run
//   word_o    : seed+idx (mod 2^DATA_WIDTH), optionally inverted
// -----------------------------------------------------------------------------
module axil_st_pattern_gen
  import axil_self_test_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned IDX_W      = 2
) (
  input  logic [DATA_WIDTH-1:0] seed_i,
  input  logic                  pat_inv_i,
  input  logic [IDX_W-1:0]      idx_i,
  output logic [DATA_WIDTH-1:0] word_o
);

  logic [DATA_WIDTH-1:0] sum_s;

  // Pattern word: wrapping sum, then optional bitwise inversion.
  always_comb begin
    sum_s = seed_i + DATA_WIDTH'(idx_i);
    if (pat_inv_i) begin
      word_o = ~sum_s;
    end else begin
      word_o = sum_s;
    end
  end

endmodule

// File: rtl/axil_seq_self_test.sv
// -----------------------------------------------------------------------------
// axil_seq_self_test
// AXI4-Lite master that writes NUM_WORDS pattern words at
// BASE_ADDR + i*ADDR_STRIDE, reads them back, and reports pass/fail together
// with a saturating error count and the index of the first failing word.
//
// Ports
//   ACLK, ARESET        : clock, synchronous active-high reset
//   start               : begin a run (honoured only in IDLE/DONE)
//   seed, pat_inv       : pattern controls, latched on an accepted start
//   busy, done, pass    : run status; pass is meaningful while done=1
//   err_count           : BRESP errors + per-word readback errors (saturating)
//   first_err_idx       : word index of the first error, 0 if none
//   timeout             : a handshake exceeded MAX_WAIT cycles
//   M_AXI_*             : AXI4-Lite master channels (PROT=0, WSTRB all ones)
//
// Optional build macro: AXIL_SELFTEST_TIMEOUT_EN enables the per-state wait
// counter and the timeout abort. Without it the sequencer waits indefinitely
// and timeout stays 0.
// -----------------------------------------------------------------------------
module axil_seq_self_test
  import axil_self_test_pkg::*;
#(
  parameter int unsigned            ADDR_WIDTH  = 32,
  parameter int unsigned            DATA_WIDTH  = 32,
  parameter int unsigned            NUM_WORDS   = 4,
  parameter logic [ADDR_WIDTH-1:0]  BASE_ADDR   = {ADDR_WIDTH{1'b0}},
  parameter int unsigned            ADDR_STRIDE = 32'd4,
  parameter int unsigned            MAX_WAIT    = 32'd255,
  localparam int unsigned           IDX_W       = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1,
  localparam int unsigned           ERR_W       = $clog2(2 * NUM_WORDS + 1)
) (
  input  logic                      ACLK,
  input  logic                      ARESET,
  input  logic                      start,
  input  logic [DATA_WIDTH-1:0]     seed,
  input  logic                      pat_inv,
  output logic                      busy,
  output logic                      done,
  output logic                      pass,
  output logic [ERR_W-1:0]          err_count,
  output logic [IDX_W-1:0]          first_err_idx,
  output logic                      timeout,
  output logic [ADDR_WIDTH-1:0]     M_AXI_AWADDR,
  output logic [2:0]                M_AXI_AWPROT,
  output logic                      M_AXI_AWVALID,
  input  logic                      M_AXI_AWREADY,
  output logic [DATA_WIDTH-1:0]     M_AXI_WDATA,
  output logic [DATA_WIDTH/8-1:0]   M_AXI_WSTRB,
  output logic                      M_AXI_WVALID,
  input  logic                      M_AXI_WREADY,
  input  logic [1:0]                M_AXI_BRESP,
  input  logic                      M_AXI_BVALID,
  output logic                      M_AXI_BREADY,
  output logic [ADDR_WIDTH-1:0]     M_AXI_ARADDR,
  output logic [2:0]                M_AXI_ARPROT,
  output logic                      M_AXI_ARVALID,
  input  logic                      M_AXI_ARREADY,
  input  logic [DATA_WIDTH-1:0]     M_AXI_RDATA,
  input  logic [1:0]                M_AXI_RRESP,
  input  logic                      M_AXI_RVALID,
  output logic                      M_AXI_RREADY
);

  state_t                  state_q, state_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [DATA_WIDTH-1:0]   seed_q, seed_d;
  logic                    inv_q, inv_d;
  logic                    awvalid_q, awvalid_d;
  logic                    wvalid_q, wvalid_d;
  logic                    aw_done_q, aw_done_d;
  logic                    w_done_q, w_done_d;
  logic                    bready_q, bready_d;
  logic                    arvalid_q, arvalid_d;
  logic                    rready_q, rready_d;
  logic [ERR_W-1:0]        err_q, err_d;
  logic [IDX_W-1:0]        first_err_q, first_err_d;
  logic                    busy_q, busy_d;
  logic                    done_q, done_d;
  logic                    pass_q, pass_d;
  logic                    timeout_q, timeout_d;

  logic [DATA_WIDTH-1:0]   exp_word_s;
  logic                    aw_hs_s, w_hs_s, ar_hs_s;
  logic                    last_s;
  logic                    err_event_s;
  logic                    finish_s;
  logic                    timeout_hit_s;

  function automatic logic [ERR_W-1:0] sat_inc(input logic [ERR_W-1:0] v);
    if (v == {ERR_W{1'b1}}) begin
      return v;
    end else begin
      return v + ERR_W'(1'b1);
    end
  endfunction

  axil_st_pattern_gen #(
    .DATA_WIDTH (DATA_WIDTH),
    .IDX_W      (IDX_W)
  ) u_pattern (
    .seed_i    (seed_q),
    .pat_inv_i (inv_q),
    .idx_i     (idx_q),
    .word_o    (exp_word_s)
  );

  assign aw_hs_s = awvalid_q & M_AXI_AWREADY;
  assign w_hs_s  = wvalid_q  & M_AXI_WREADY;
  assign ar_hs_s = arvalid_q & M_AXI_ARREADY;
  assign last_s  = (idx_q == IDX_W'(NUM_WORDS - 1));

`ifdef AXIL_SELFTEST_TIMEOUT_EN
  localparam int unsigned WAIT_W = $clog2(MAX_WAIT + 1);

  logic [WAIT_W-1:0] wait_q, wait_d;
  logic              active_s;

  assign active_s      = (state_q == ST_WR_REQ) || (state_q == ST_WR_RESP) ||
                         (state_q == ST_RD_REQ) || (state_q == ST_RD_RESP);
  assign timeout_hit_s = active_s && (wait_q == WAIT_W'(MAX_WAIT));

  // Wait counter: restarts on every state change, idles at zero outside the AXI states.
  always_comb begin
    wait_d = wait_q;
    if ((state_d != state_q) || !active_s) begin
      wait_d = {WAIT_W{1'b0}};
    end else begin
      wait_d = wait_q + WAIT_W'(1'b1);
    end
  end

  // Wait counter register.
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      wait_q <= {WAIT_W{1'b0}};
    end else begin
      wait_q <= wait_d;
    end
  end
`else
  assign timeout_hit_s = 1'b0;
`endif

  // Sequencer next-state, channel controls and status bookkeeping.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    addr_d      = addr_q;
    seed_d      = seed_q;
    inv_d       = inv_q;
    awvalid_d   = awvalid_q;
    wvalid_d    = wvalid_q;
    aw_done_d   = aw_done_q;
    w_done_d    = w_done_q;
    bready_d    = bready_q;
    arvalid_d   = arvalid_q;
    rready_d    = rready_q;
    err_d       = err_q;
    first_err_d = first_err_q;
    busy_d      = busy_q;
    done_d      = done_q;
    pass_d      = pass_q;
    timeout_d   = timeout_q;
    err_event_s = 1'b0;
    finish_s    = 1'b0;

    if (timeout_hit_s) begin
      // Abort: release every channel and report a failed run.
      state_d   = ST_DONE;
      awvalid_d = 1'b0;
      wvalid_d  = 1'b0;
      bready_d  = 1'b0;
      arvalid_d = 1'b0;
      rready_d  = 1'b0;
      busy_d    = 1'b0;
      done_d    = 1'b1;
      pass_d    = 1'b0;
      timeout_d = 1'b1;
    end else begin
      case (state_q)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            state_d     = ST_WR_REQ;
            idx_d       = {IDX_W{1'b0}};
            addr_d      = BASE_ADDR;
            seed_d      = seed;
            inv_d       = pat_inv;
            awvalid_d   = 1'b1;
            wvalid_d    = 1'b1;
            aw_done_d   = 1'b0;
            w_done_d    = 1'b0;
            err_d       = {ERR_W{1'b0}};
            first_err_d = {IDX_W{1'b0}};
            busy_d      = 1'b1;
            done_d      = 1'b0;
            pass_d      = 1'b0;
            timeout_d   = 1'b0;
          end else begin
            state_d = state_q;
          end
        end

        ST_WR_REQ: begin
          // AW and W complete independently; each VALID drops after its own handshake.
          if (aw_hs_s) begin
            awvalid_d = 1'b0;
            aw_done_d = 1'b1;
          end else begin
            awvalid_d = awvalid_q;
          end
          if (w_hs_s) begin
            wvalid_d = 1'b0;
            w_done_d = 1'b1;
          end else begin
            wvalid_d = wvalid_q;
          end
          if (aw_done_d && w_done_d) begin
            state_d  = ST_WR_RESP;
            bready_d = 1'b1;
          end else begin
            state_d = state_q;
          end
        end

        ST_WR_RESP: begin
          if (M_AXI_BVALID) begin
            bready_d    = 1'b0;
            err_event_s = !resp_is_okay(M_AXI_BRESP);
            if (last_s) begin
              state_d   = ST_RD_REQ;
              idx_d     = {IDX_W{1'b0}};
              addr_d    = BASE_ADDR;
              arvalid_d = 1'b1;
            end else begin
              state_d   = ST_WR_REQ;
              idx_d     = idx_q + IDX_W'(1'b1);
              addr_d    = addr_q + ADDR_WIDTH'(ADDR_STRIDE);
              awvalid_d = 1'b1;
              wvalid_d  = 1'b1;
              aw_done_d = 1'b0;
              w_done_d  = 1'b0;
            end
          end else begin
            state_d = state_q;
          end
        end

        ST_RD_REQ: begin
          if (ar_hs_s) begin
            arvalid_d = 1'b0;
            rready_d  = 1'b1;
            state_d   = ST_RD_RESP;
          end else begin
            state_d = state_q;
          end
        end

        ST_RD_RESP: begin
          if (M_AXI_RVALID) begin
            rready_d = 1'b0;
            // Bad data and a bad response on the same word count as one error.
            err_event_s = !resp_is_okay(M_AXI_RRESP) || (M_AXI_RDATA != exp_word_s);
            if (last_s) begin
              state_d  = ST_DONE;
              finish_s = 1'b1;
              busy_d   = 1'b0;
              done_d   = 1'b1;
            end else begin
              state_d   = ST_RD_REQ;
              idx_d     = idx_q + IDX_W'(1'b1);
              addr_d    = addr_q + ADDR_WIDTH'(ADDR_STRIDE);
              arvalid_d = 1'b1;
            end
          end else begin
            state_d = state_q;
          end
        end

        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end

    // A zero count means no earlier error, so this is the first failing word.
    first_err_d = (err_event_s && (err_q == {ERR_W{1'b0}})) ? idx_q : first_err_d;
    err_d       = err_event_s ? sat_inc(err_q) : err_d;
    pass_d      = finish_s ? (err_d == {ERR_W{1'b0}}) : pass_d;
  end

  // Sequencer and status registers.
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      state_q     <= ST_IDLE;
      idx_q       <= {IDX_W{1'b0}};
      addr_q      <= {ADDR_WIDTH{1'b0}};
      seed_q      <= {DATA_WIDTH{1'b0}};
      inv_q       <= 1'b0;
      awvalid_q   <= 1'b0;
      wvalid_q    <= 1'b0;
      aw_done_q   <= 1'b0;
      w_done_q    <= 1'b0;
      bready_q    <= 1'b0;
      arvalid_q   <= 1'b0;
      rready_q    <= 1'b0;
      err_q       <= {ERR_W{1'b0}};
      first_err_q <= {IDX_W{1'b0}};
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      pass_q      <= 1'b0;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      addr_q      <= addr_d;
      seed_q      <= seed_d;
      inv_q       <= inv_d;
      awvalid_q   <= awvalid_d;
      wvalid_q    <= wvalid_d;
      aw_done_q   <= aw_done_d;
      w_done_q    <= w_done_d;
      bready_q    <= bready_d;
      arvalid_q   <= arvalid_d;
      rready_q    <= rready_d;
      err_q       <= err_d;
      first_err_q <= first_err_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      pass_q      <= pass_d;
      timeout_q   <= timeout_d;
    end
  end

  assign busy          = busy_q;
  assign done          = done_q;
  assign pass          = pass_q;
  assign err_count     = err_q;
  assign first_err_idx = first_err_q;
  assign timeout       = timeout_q;

  assign M_AXI_AWADDR  = addr_q;
  assign M_AXI_AWPROT  = 3'b000;
  assign M_AXI_AWVALID = awvalid_q;
  assign M_AXI_WDATA   = exp_word_s;
  assign M_AXI_WSTRB   = {(DATA_WIDTH/8){1'b1}};
  assign M_AXI_WVALID  = wvalid_q;
  assign M_AXI_BREADY  = bready_q;
  assign M_AXI_ARADDR  = addr_q;
  assign M_AXI_ARPROT  = 3'b000;
  assign M_AXI_ARVALID = arvalid_q;
  assign M_AXI_RREADY  = rready_q;

endmodule

// File: tb/tb_axil_seq_self_test.sv
module tb_axil_seq_self_test;
  import axil_self_test_pkg::*;

  localparam int NW = 4;

  logic        ACLK = 1'b0;
  logic        ARESET;
  logic        start;
  logic [31:0] seed;
  logic        pat_inv;
  logic        busy, done, pass, timeout;
  logic [3:0]  err_count;
  logic [1:0]  first_err_idx;
  logic [31:0] AWADDR, WDATA, ARADDR, RDATA;
  logic [2:0]  AWPROT, ARPROT;
  logic [3:0]  WSTRB;
  logic        AWVALID, AWREADY, WVALID, WREADY, BVALID, BREADY;
  logic        ARVALID, ARREADY, RVALID, RREADY;
  logic [1:0]  BRESP, RRESP;

  always #5 ACLK = ~ACLK;

  axil_seq_self_test #(
    .ADDR_WIDTH (32), .DATA_WIDTH (32), .NUM_WORDS (NW),
    .BASE_ADDR (32'h0000_0000), .ADDR_STRIDE (32'd4), .MAX_WAIT (32'd16)
  ) dut (
    .ACLK (ACLK), .ARESET (ARESET), .start (start), .seed (seed), .pat_inv (pat_inv),
    .busy (busy), .done (done), .pass (pass), .err_count (err_count),
    .first_err_idx (first_err_idx), .timeout (timeout),
    .M_AXI_AWADDR (AWADDR), .M_AXI_AWPROT (AWPROT), .M_AXI_AWVALID (AWVALID),
    .M_AXI_AWREADY (AWREADY), .M_AXI_WDATA (WDATA), .M_AXI_WSTRB (WSTRB),
    .M_AXI_WVALID (WVALID), .M_AXI_WREADY (WREADY), .M_AXI_BRESP (BRESP),
    .M_AXI_BVALID (BVALID), .M_AXI_BREADY (BREADY), .M_AXI_ARADDR (ARADDR),
    .M_AXI_ARPROT (ARPROT), .M_AXI_ARVALID (ARVALID), .M_AXI_ARREADY (ARREADY),
    .M_AXI_RDATA (RDATA), .M_AXI_RRESP (RRESP), .M_AXI_RVALID (RVALID),
    .M_AXI_RREADY (RREADY)
  );

  // ---------------- slave model (RAM with fault knobs) ----------------
  int          aw_delay    = 0;
  int          corrupt_idx = -1;
  int          bresp_idx   = -1;
  bit          ar_block    = 1'b0;
  logic [31:0] mem [0:15];
  int          aw_cnt;
  logic        aw_got, w_got;
  logic [31:0] aw_lat, w_lat;
  logic        aw_hs, w_hs, have_aw, have_w;
  logic [31:0] wr_addr, wr_data;

  assign AWREADY = (aw_cnt >= aw_delay);
  assign WREADY  = 1'b1;
  assign ARREADY = !ar_block && !RVALID;
  assign aw_hs   = AWVALID && AWREADY;
  assign w_hs    = WVALID && WREADY;
  assign have_aw = aw_got || aw_hs;
  assign have_w  = w_got || w_hs;
  assign wr_addr = aw_got ? aw_lat : AWADDR;
  assign wr_data = w_got ? w_lat : WDATA;

  always @(posedge ACLK) begin
    if (ARESET) begin
      aw_cnt <= 0; aw_got <= 1'b0; w_got <= 1'b0;
      BVALID <= 1'b0; BRESP <= 2'b00; RVALID <= 1'b0; RRESP <= 2'b00; RDATA <= 32'h0;
    end else begin
      if (aw_hs) aw_cnt <= 0;
      else if (AWVALID) aw_cnt <= aw_cnt + 1;
      if (BVALID && BREADY) BVALID <= 1'b0;
      if (have_aw && have_w) begin
        mem[wr_addr[5:2]] <= wr_data;
        BVALID <= 1'b1;
        BRESP  <= (int'(wr_addr[5:2]) == bresp_idx) ? AXI_RESP_SLVERR : AXI_RESP_OKAY;
        aw_got <= 1'b0; w_got <= 1'b0;
      end else begin
        if (aw_hs) begin aw_got <= 1'b1; aw_lat <= AWADDR; end
        if (w_hs)  begin w_got  <= 1'b1; w_lat  <= WDATA;  end
      end
      if (ARVALID && ARREADY) begin
        RVALID <= 1'b1;
        RRESP  <= AXI_RESP_OKAY;
        RDATA  <= (int'(ARADDR[5:2]) == corrupt_idx) ? 32'h0 : mem[ARADDR[5:2]];
      end else if (RVALID && RREADY) begin
        RVALID <= 1'b0;
      end
    end
  end

  // ---------------- scoreboard ----------------
  typedef struct {
    logic       pass;
    logic [3:0] err;
    logic [1:0] fei;
    logic       to;
  } res_t;

  logic [31:0] exp_aw[$], exp_w[$], exp_ar[$];
  res_t        exp_res[$];
  int          checks = 0;
  int          errors = 0;

  function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endfunction

  function automatic void miss(input string name);
    checks++;
    errors++;
    $display("FAIL %s: DUT output with no expected entry queued (t=%0t)", name, $time);
  endfunction

  logic        aw_pend, w_pend, ar_pend, done_prev;
  logic [31:0] aw_prev, w_prev, ar_prev;
  res_t        r;

  // Monitor: sampled on the falling edge, away from the active edge.
  always @(negedge ACLK) begin
    if (ARESET) begin
      aw_pend <= 1'b0; w_pend <= 1'b0; ar_pend <= 1'b0; done_prev <= 1'b0;
    end else begin
      if (aw_pend && !done) begin
        check("awvalid_held", AWVALID, 1'b1);
        check("awaddr_stable", AWADDR, aw_prev);
      end
      if (w_pend && !done) begin
        check("wvalid_held", WVALID, 1'b1);
        check("wdata_stable", WDATA, w_prev);
      end
      if (ar_pend && !done) begin
        check("arvalid_held", ARVALID, 1'b1);
        check("araddr_stable", ARADDR, ar_prev);
      end
      if (AWVALID && AWREADY) begin
        if (exp_aw.size() == 0) miss("awaddr");
        else check("awaddr", AWADDR, exp_aw.pop_front());
        check("awprot", AWPROT, 3'b000);
      end
      if (WVALID && WREADY) begin
        if (exp_w.size() == 0) miss("wdata");
        else check("wdata", WDATA, exp_w.pop_front());
        check("wstrb", WSTRB, 4'hF);
      end
      if (ARVALID && ARREADY) begin
        if (exp_ar.size() == 0) miss("araddr");
        else check("araddr", ARADDR, exp_ar.pop_front());
      end
      if (done && !done_prev) begin
        if (exp_res.size() == 0) miss("run_result");
        else begin
          r = exp_res.pop_front();
          check("pass", pass, r.pass);
          check("err_count", err_count, r.err);
          check("first_err_idx", first_err_idx, r.fei);
          check("timeout", timeout, r.to);
          check("busy_at_done", busy, 1'b0);
        end
      end
      aw_pend   <= AWVALID && !AWREADY;
      w_pend    <= WVALID && !WREADY;
      ar_pend   <= ARVALID && !ARREADY;
      aw_prev   <= AWADDR;
      w_prev    <= WDATA;
      ar_prev   <= ARADDR;
      done_prev <= done;
    end
  end

  // ---------------- stimulus ----------------
  task automatic push_run(input logic [31:0] w0, w1, w2, w3);
    logic [31:0] wd [4];
    wd = '{w0, w1, w2, w3};
    for (int i = 0; i < NW; i++) begin
      exp_aw.push_back(32'(i * 4));
      exp_w.push_back(wd[i]);
      exp_ar.push_back(32'(i * 4));
    end
  endtask

  task automatic run(input logic [31:0] s, input logic inv,
                     input logic [31:0] w0, w1, w2, w3,
                     input logic ep, input logic [3:0] ee, input logic [1:0] ef, input logic eto,
                     input int exp_lat, input int glitch);
    res_t e;
    int   n;
    push_run(w0, w1, w2, w3);
    e.pass = ep; e.err = ee; e.fei = ef; e.to = eto;
    exp_res.push_back(e);
    @(negedge ACLK);
    seed = s; pat_inv = inv; start = 1'b1;
    @(negedge ACLK);
    start = 1'b0;
    seed  = 32'h5A5A_5A5A;
    check("busy_rise", busy, 1'b1);
    check("done_clear", done, 1'b0);
    n = 1;
    while (!done && n < 300) begin
      start = (n == glitch);
      @(negedge ACLK);
      n++;
    end
    start = 1'b0;
    if (n >= 300) begin
      errors++;
      checks++;
      $display("FAIL run_wait: done not seen within %0d cycles", n);
    end else if (exp_lat != 0) begin
      check("latency", n, exp_lat);
    end
    @(negedge ACLK);
  endtask

  initial begin
    ARESET = 1'b1; start = 1'b0; seed = 32'h0; pat_inv = 1'b0;
    repeat (3) @(negedge ACLK);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_pass", pass, 1'b0);
    check("rst_err", err_count, 4'd0);
    check("rst_fei", first_err_idx, 2'd0);
    check("rst_timeout", timeout, 1'b0);
    check("rst_awvalid", AWVALID, 1'b0);
    check("rst_wvalid", WVALID, 1'b0);
    check("rst_bready", BREADY, 1'b0);
    check("rst_arvalid", ARVALID, 1'b0);
    check("rst_rready", RREADY, 1'b0);
    ARESET = 1'b0;
    @(negedge ACLK);

    // zero-wait baseline: 1,2,3,4 at 0x0..0xC, latency 4*NW+1
    run(32'h1, 1'b0, 32'h1, 32'h2, 32'h3, 32'h4, 1'b1, 4'd0, 2'd0, 1'b0, 17, 0);
    // readback of word 2 corrupted to zero
    corrupt_idx = 2;
    run(32'h1, 1'b0, 32'h1, 32'h2, 32'h3, 32'h4, 1'b0, 4'd1, 2'd2, 1'b0, 17, 0);
    corrupt_idx = -1;
    // AWREADY three cycles late, WREADY immediate
    aw_delay = 3;
    run(32'h1, 1'b0, 32'h1, 32'h2, 32'h3, 32'h4, 1'b1, 4'd0, 2'd0, 1'b0, 0, 0);
    aw_delay = 0;
    // wrapping seed with inverted pattern
    run(32'hFFFF_FFFF, 1'b1, 32'h0, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'hFFFF_FFFD,
        1'b1, 4'd0, 2'd0, 1'b0, 17, 0);
    // SLVERR on write of word 0
    bresp_idx = 0;
    run(32'h1, 1'b0, 32'h1, 32'h2, 32'h3, 32'h4, 1'b0, 4'd1, 2'd0, 1'b0, 17, 0);
    // write error on word 3 precedes read error on word 1
    bresp_idx = 3; corrupt_idx = 1;
    run(32'h1, 1'b0, 32'h1, 32'h2, 32'h3, 32'h4, 1'b0, 4'd2, 2'd3, 1'b0, 17, 0);
    bresp_idx = -1; corrupt_idx = -1;
    // start pulse while busy must be ignored
    run(32'h10, 1'b0, 32'h10, 32'h11, 32'h12, 32'h13, 1'b1, 4'd0, 2'd0, 1'b0, 17, 5);

    // reset in the middle of a run
    push_run(32'h1, 32'h2, 32'h3, 32'h4);
    @(negedge ACLK);
    seed = 32'h1; pat_inv = 1'b0; start = 1'b1;
    @(negedge ACLK);
    start = 1'b0;
    repeat (5) @(negedge ACLK);
    ARESET = 1'b1;
    @(negedge ACLK);
    check("midrst_busy", busy, 1'b0);
    check("midrst_done", done, 1'b0);
    check("midrst_awvalid", AWVALID, 1'b0);
    check("midrst_wvalid", WVALID, 1'b0);
    check("midrst_arvalid", ARVALID, 1'b0);
    ARESET = 1'b0;
    exp_aw.delete(); exp_w.delete(); exp_ar.delete();
    repeat (4) @(negedge ACLK);
    check("midrst_idle_done", done, 1'b0);
    check("midrst_idle_busy", busy, 1'b0);
    run(32'h7, 1'b0, 32'h7, 32'h8, 32'h9, 32'hA, 1'b1, 4'd0, 2'd0, 1'b0, 17, 0);

`ifdef AXIL_SELFTEST_TIMEOUT_EN
    // ARREADY never rises: timeout after MAX_WAIT cycles in RD_REQ
    ar_block = 1'b1;
    run(32'h1, 1'b0, 32'h1, 32'h2, 32'h3, 32'h4, 1'b0, 4'd0, 2'd0, 1'b1, 0, 0);
    check("to_arvalid_low", ARVALID, 1'b0);
    check("to_done", done, 1'b1);
    exp_ar.delete();
    ar_block = 1'b0;
`endif

    repeat (2) @(negedge ACLK);
    check("queues_drained", exp_aw.size() + exp_w.size() + exp_ar.size() + exp_res.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
